// File: rtl/dpll_pkg.sv
// Shared widths, reset constants and encoding helpers for the DPLL controller family.
package dpll_pkg;

  typedef enum logic {
    STEP_FINE   = 1'b0,
    STEP_COARSE = 1'b1
  } step_sel_e;

  function automatic int unsigned tv_width(input int unsigned trim_w, input int unsigned frac_w);
    return $clog2(trim_w + 1) + frac_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned div_w);
    return div_w + 2;
  endfunction

  function automatic int unsigned mid_code(input int unsigned trim_w, input int unsigned frac_w);
    return (trim_w / 2) << frac_w;
  endfunction

  // Coarse moves one whole trim tap, fine moves one fractional LSB
  function automatic int unsigned step_size(input step_sel_e sel, input int unsigned frac_w);
    return (sel == STEP_COARSE) ? (32'd1 << frac_w) : 32'd1;
  endfunction

  // Thermometer tap idx is on when the integer trim level exceeds it
  function automatic logic therm_bit(input int unsigned level, input int unsigned idx);
    return level > idx;
  endfunction

endpackage

// File: rtl/dpll_ref_sync.sv
// Two-flop synchronizer for an asynchronous reference plus a one-cycle rising-edge pulse.
module dpll_ref_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/dpll_ctrl_v2.sv
// DPLL/FLL controller: measures DCO cycles per reference period and steers a
// fractional trim accumulator with coarse/fine gain, lock and reference-loss detection.
module dpll_ctrl_v2
  import dpll_pkg::*;
#(
  parameter int unsigned DIV_W      = 5,
  parameter int unsigned TRIM_W     = 26,
  parameter int unsigned FRAC_W     = 3,
  parameter int unsigned TOL        = 0,
  parameter int unsigned COARSE_THR = 2,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic                                 clock,
  input  logic                                 resetb,
  input  logic                                 enable,
  input  logic                                 osc,
  input  logic [DIV_W-1:0]                     div,
  input  logic                                 ext_trim_en,
  input  logic [TRIM_W-1:0]                    ext_trim,
  output logic [TRIM_W-1:0]                    trim,
  output logic [tv_width(TRIM_W, FRAC_W)-1:0]  tval,
  output logic                                 locked,
  output logic                                 ref_lost
);

  localparam int unsigned TV_W  = tv_width(TRIM_W, FRAC_W);
  localparam int unsigned TV1_W = TV_W + 1;
  localparam int unsigned CNT_W = cnt_width(DIV_W);
  localparam int unsigned ERR_W = CNT_W + 1;
  localparam int unsigned LK_W  = $clog2(LOCK_CNT + 1);

  localparam logic [TV_W-1:0]   TV_MID   = TV_W'(mid_code(TRIM_W, FRAC_W));
  localparam logic [TV1_W-1:0]  TV_MAX   = TV1_W'(TRIM_W << FRAC_W);
  localparam logic [TRIM_W-1:0] TRIM_RST = TRIM_W'((64'd1 << (TRIM_W / 2)) - 64'd1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
  localparam logic [LK_W-1:0]   LK_FULL  = LK_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0]  TOL_E    = ERR_W'(TOL);
  localparam logic [ERR_W-1:0]  COARSE_E = ERR_W'(COARSE_THR);

  logic ref_edge_c;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              primed_q, primed_d;
  logic [LK_W-1:0]   lock_q, lock_d;
  logic [TV_W-1:0]   tval_q, tval_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic              locked_q, locked_d;
  logic              ref_lost_q, ref_lost_d;

  logic signed [ERR_W-1:0] err_c;
  logic [ERR_W-1:0]        err_abs_c;
  logic                    in_tol_c;
  step_sel_e               step_sel_c;
  logic [TV1_W-1:0]        step_c;
  logic [TV1_W-1:0]        tv_up_c;
  logic [TRIM_W-1:0]       therm_c;

  dpll_ref_sync u_ref_sync (
    .clk      (clock),
    .rst_n    (resetb),
    .async_in (osc),
    .rise_c   (ref_edge_c)
  );

  // Period error, its magnitude, and the resulting accumulator step
  always_comb begin
    err_c      = ERR_W'({1'b0, cnt_q}) - ERR_W'(div);
    err_abs_c  = err_c[ERR_W-1] ? ERR_W'(-err_c) : ERR_W'(err_c);
    in_tol_c   = err_abs_c <= TOL_E;
    step_sel_c = (err_abs_c > COARSE_E) ? STEP_COARSE : STEP_FINE;
    step_c     = TV1_W'(step_size(step_sel_c, FRAC_W));
    tv_up_c    = {1'b0, tval_q} + step_c;
    therm_c    = '0;
    for (int unsigned i = 0; i < TRIM_W; i++) begin
      therm_c[i] = therm_bit(32'(tval_q >> FRAC_W), i);
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    lock_d     = lock_q;
    tval_d     = tval_q;
    ref_lost_d = ref_lost_q;

    if (!enable) begin
      cnt_d      = '0;
      primed_d   = 1'b0;
      lock_d     = '0;
      ref_lost_d = 1'b0;
    end else if (ref_edge_c) begin
      cnt_d      = CNT_W'(1);
      ref_lost_d = 1'b0;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (!ext_trim_en) begin
        if (in_tol_c) begin
          lock_d = (lock_q == LK_FULL) ? lock_q : lock_q + LK_W'(1);
        end else begin
          lock_d = '0;
          if (!err_c[ERR_W-1]) begin
            tval_d = (tv_up_c > TV_MAX) ? TV_MAX[TV_W-1:0] : tv_up_c[TV_W-1:0];
          end else begin
            tval_d = ({1'b0, tval_q} < step_c) ? '0 : TV_W'({1'b0, tval_q} - step_c);
          end
        end
      end
    end else if (cnt_q == CNT_SAT) begin
      ref_lost_d = 1'b1;
      primed_d   = 1'b0;
      lock_d     = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Override freezes the loop; the next edge after release re-primes it
    if (ext_trim_en) begin
      primed_d = 1'b0;
      lock_d   = '0;
    end

    locked_d = (lock_d == LK_FULL);
    trim_d   = ext_trim_en ? ext_trim : therm_c;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      lock_q     <= '0;
      tval_q     <= TV_MID;
      trim_q     <= TRIM_RST;
      locked_q   <= 1'b0;
      ref_lost_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      lock_q     <= lock_d;
      tval_q     <= tval_d;
      trim_q     <= trim_d;
      locked_q   <= locked_d;
      ref_lost_q <= ref_lost_d;
    end
  end

  assign trim     = trim_q;
  assign tval     = tval_q;
  assign locked   = locked_q;
  assign ref_lost = ref_lost_q;

endmodule

// File: doc/dpll_ctrl_v2.md
Name: dpll_ctrl_v2

Overview:
- Parametrised second-generation digital PLL / frequency-locked-loop controller for the user project area.
- Clocked by the DCO output. Counts DCO cycles per rising edge of the slow reference `osc` and compares the count against the programmed divider `div`.
- Steers a fractional trim accumulator whose integer part drives a thermometer trim bus to the ring oscillator.
- Adds features the first-generation PLL lacks: coarse/fine step gain, lock detection, reference-loss detection, and a manual trim override.

Parameters:
- DIV_W, 5: divider (`div`) width.
- TRIM_W, 26: number of thermometer trim taps.
- FRAC_W, 3: fractional bits in the trim accumulator.
- TOL, 0: allowed |count - div| for a period to count as in-lock.
- COARSE_THR, 2: if |err| > COARSE_THR, use the coarse step (1<<FRAC_W); otherwise use the fine step (1).
- LOCK_CNT, 4: consecutive in-tolerance periods needed to assert `locked`.

Ports:
- clock, input, 1: DCO-derived controller clock.
- resetb, input, 1: reset.
- enable, input, 1: loop enable.
- osc, input, 1: reference oscillator; asynchronous to `clock`.
- div, input, DIV_W: target DCO cycles per reference period.
- ext_trim_en, input, 1: manual trim override.
- ext_trim, input, TRIM_W: manual trim value.
- trim, output, TRIM_W: thermometer trim to the DCO; higher code = slower DCO.
- tval, output, TV_W: accumulator observation, TV_W = clog2(TRIM_W+1)+FRAC_W.
- locked, output, 1: lock indicator.
- ref_lost, output, 1: reference missing.

Behaviour:
- **Interface:** one clock; reset is asynchronous and active-low. Ports are named `clock` / `resetb`.
- **Reset values:**
  - tval = MID = (TRIM_W/2)<<FRAC_W; default 104.
  - trim = thermometer(TRIM_W/2); default 26'h0001FFF.
  - locked = 0, ref_lost = 0.
  - Period counter = 0, lock counter = 0, primed = 0.
- **Reference sync:** `osc` passes through a 2-flop synchronizer, then a rising-edge detect giving a one-cycle `ref_edge` pulse. Latency is fixed at 3 clocks, so it does not affect the measured period.
- **Period counter:**
  - Width CNT_W = DIV_W+2.
  - Increments every clock and saturates at 2^CNT_W-1.
  - On `ref_edge`: captures `cnt`, then sets `cnt` to 1. A reference period of N clocks therefore captures N.
- **First edge:** the first `ref_edge` after reset, enable rise, or ref_lost clear sets primed = 1 and makes no tval/lock update.
- **Update on a primed `ref_edge`:** err = cnt - div, signed, CNT_W+1 bits.
  - err > TOL (DCO fast): tval += step.
  - err < -TOL (DCO slow): tval -= step.
  - Otherwise tval is unchanged.
  - tval saturates at 0 and at TRIM_W<<FRAC_W (default 208); no wrap-around.
- **Trim output:**
  - trim[i] = (tval>>FRAC_W) > i.
  - Registered, so it follows tval one clock later.
- **Lock detection:**
  - A primed capture with |err| <= TOL increments the lock counter, saturating at LOCK_CNT.
  - `locked` = 1 when the counter reaches LOCK_CNT.
  - Any out-of-tolerance capture clears the counter and drops `locked` in the same update.
- **Reference loss:**
  - When `cnt` hits saturation, set ref_lost = 1, locked = 0, primed = 0, lock counter = 0; tval is held.
  - The next `ref_edge` clears ref_lost; that edge is unprimed.
  - If `ref_edge` and saturation occur in the same cycle, the edge wins.
- **enable = 0:**
  - Counters and primed are cleared; locked = 0, ref_lost = 0.
  - tval is held (not reset), and trim keeps following tval.
- **ext_trim_en = 1:**
  - trim = ext_trim, registered one clock later.
  - tval is frozen and locked = 0.
  - Period counting and ref_lost detection continue.
  - On deassert, trim returns to thermometer(tval) on the next clock and primed is cleared.
- **Reset mid-operation:** asynchronously forces all reset values immediately.

Decomposition:
- Package `dpll_pkg`:
  - Width helper functions: TV_W, CNT_W.
  - MID constant computation.
  - Thermometer-encode function.
  - Step-select constants.
- Sub-module `dpll_ref_sync`: 2-flop synchronizer plus rising-edge pulse, with async active-low reset. It is reused by later clock blocks.

Test Plan (default parameters):
1. Reset: resetb = 0 with clock running -> tval = 104, trim = 26'h0001FFF, locked = 0, ref_lost = 0. Release reset, then the first osc edge -> no tval change.
2. div = 16, osc period 20 clocks -> err = +4, coarse step. tval = 112 after the second edge and trim = 26'h0003FFF one clock later. Then 120, and so on.
3. div = 16, osc period 17 -> fine step: tval 104 -> 105 -> 106, and trim stays 26'h0001FFF until tval reaches 112.
4. div = 16, period 16 for 4 primed edges -> locked = 1 after the 4th capture. One period of 18 -> locked = 0 and tval += 1 at that edge.
5. osc held low -> ref_lost = 1 and locked = 0 after cnt reaches 127, tval held. Restart osc -> ref_lost clears on the first edge with no update; updates resume from the second edge.
6. Corners:
   - ext_trim_en = 1, ext_trim = 26'h3FFFFFF -> trim = 26'h3FFFFFF next clock, tval frozen.
   - Release override, then div = 8 with period 40 repeated -> tval saturates at 208 and trim = 26'h3FFFFFF with no wrap.
   - Period 2, div = 31 repeated -> tval saturates at 0 and trim = 0.
